// File: rtl/coco_serial_pkg.sv
// Shared types and constants for the CoCo bit-banger serial path.
package coco_serial_pkg;

  localparam int unsigned DIV_W            = 20;
  localparam int unsigned DIV_MIN          = 8;
  localparam int unsigned DEFAULT_600_BAUD = 95453;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  // 0 selects the default period; tiny divisors are clamped so mid-bit sampling stays meaningful
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] req,
                                               input logic [DIV_W-1:0] dflt);
    if (req == '0)
      return dflt;
    else if (req < DIV_W'(DIV_MIN))
      return DIV_W'(DIV_MIN);
    return req;
  endfunction

endpackage

// File: rtl/coco_rx_fifo.sv
// Synchronous FIFO, FIFO_DEPTH x WIDTH, wrap-bit pointers; pop is honoured before push when full.
module coco_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        mem[AW'(i)] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop)
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/coco_rs232_rx.sv
// Receiver for the CoCo bit-banged rsout1 line: 8N1 by default, 8E1 when COCO_RX_PARITY_EN is defined.
module coco_rs232_rx
  import coco_serial_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter bit          IDLE_LEVEL  = 1'b1,
  parameter int unsigned DEFAULT_DIV = DEFAULT_600_BAUD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  input  logic [DIV_W-1:0] bit_div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err,
  input  logic             err_clr,
  output logic             busy
);

  logic             sync1;
  logic             sync2;
  logic             line;
  logic             line_d;
  rx_state_e        state;
  logic [DIV_W-1:0] d_eff;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] tmr;
  logic             tmr_exp;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  // internal line is always 1 for mark, whatever the physical idle level
  assign line    = sync2 ^ ~IDLE_LEVEL;
  assign d_eff   = eff_div(bit_div, DIV_W'(DEFAULT_DIV));
  assign tmr_exp = (tmr == DIV_W'(1));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= IDLE_LEVEL;
      sync2  <= IDLE_LEVEL;
      line_d <= 1'b1;
    end else begin
      sync1  <= rx_in;
      sync2  <= sync1;
      line_d <= line;
    end
  end

`ifdef COCO_RX_PARITY_EN
  logic par_err_q;
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div_q     <= '0;
      tmr       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef COCO_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      tmr  <= tmr - DIV_W'(1);
      // clears come first so a set later in this block wins the same cycle
      if (err_clr) begin
        frame_err <= 1'b0;
`ifdef COCO_RX_PARITY_EN
        par_err_q <= 1'b0;
`endif
      end
      case (state)
        IDLE: begin
          if (line_d && !line) begin
            div_q <= d_eff;
            tmr   <= d_eff >> 1;
            state <= START;
          end
        end
        START: begin
          if (tmr_exp) begin
            if (!line) begin
              tmr     <= div_q;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tmr_exp) begin
            shreg   <= {line, shreg[7:1]};
            tmr     <= div_q;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef COCO_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef COCO_RX_PARITY_EN
        PARITY: begin
          if (tmr_exp) begin
            if (line != ^shreg)
              par_err_q <= 1'b1;
            tmr   <= div_q;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tmr_exp) begin
            if (line) begin
              push  <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (line)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_valid = !fifo_empty;
  assign fifo_pop = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (push && fifo_full && !fifo_pop)
      overrun <= 1'b1;
    else if (err_clr)
      overrun <= 1'b0;
  end

  coco_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (8)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wr_data(shreg),
    .pop    (fifo_pop),
    .rd_data(rx_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_coco_rs232_rx.sv
// Directed bench for coco_rs232_rx; frames carry a parity bit when COCO_RX_PARITY_EN is defined.
module tb_coco_rs232_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_in;
  logic [19:0] bit_div;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_err;
  logic        overrun;
  logic        parity_err;
  logic        err_clr;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  rxq[$];

  coco_rs232_rx #(
    .FIFO_DEPTH (8),
    .IDLE_LEVEL (1'b1),
    .DEFAULT_DIV(64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .bit_div   (bit_div),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // record every byte that the consumer accepts
  always @(negedge clk)
    if (!reset && rx_valid && rx_ready)
      rxq.push_back(rx_data);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] qat(input int unsigned idx);
    if (idx < rxq.size())
      return {24'h0, rxq[idx]};
    return 32'hdead;
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] data, input int unsigned div,
                            input logic stop_lvl, input logic par_flip);
    rx_in = 1'b0;
    tick(div);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      tick(div);
    end
`ifdef COCO_RX_PARITY_EN
    rx_in = (^data) ^ par_flip;
    tick(div);
`endif
    rx_in = stop_lvl;
    tick(div);
  endtask

  task automatic send_byte(input logic [7:0] data, input int unsigned div);
    send_frame(data, div, 1'b1, 1'b0);
    tick(div);
  endtask

  initial begin
    reset    = 1'b1;
    rx_in    = 1'b1;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    bit_div  = 20'd100;
    tick(3);
    reset = 1'b0;
    tick(2);

    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_busy", busy, 0);

    // two back-to-back bytes at 100 clk/bit
    rx_ready = 1'b1;
    send_byte(8'h55, 100);
    send_byte(8'hA3, 100);
    tick(10);
    check("two_count", rxq.size(), 2);
    check("byte_55", qat(0), 32'h55);
    check("byte_a3", qat(1), 32'hA3);
    check("two_frame_err", frame_err, 0);
    check("two_overrun", overrun, 0);
    rxq.delete();

    // short low pulse is rejected at the start-bit sample
    rx_ready = 1'b0;
    rx_in = 1'b0;
    tick(30);
    rx_in = 1'b1;
    tick(300);
    check("glitch_valid", rx_valid, 0);
    check("glitch_frame_err", frame_err, 0);
    check("glitch_busy", busy, 0);

    // stop bit low followed by a long break: one error, no byte
    rx_ready = 1'b1;
    send_frame(8'h41, 100, 1'b0, 1'b0);
    check("brk_frame_err_set", frame_err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(2000);
    check("brk_no_retrigger", frame_err, 0);
    check("brk_busy", busy, 1);
    check("brk_no_byte", rxq.size(), 0);
    rx_in = 1'b1;
    tick(100);
    check("brk_idle", busy, 0);
    send_byte(8'h42, 100);
    tick(10);
    check("after_brk_count", rxq.size(), 1);
    check("after_brk_byte", qat(0), 32'h42);
    check("after_brk_frame_err", frame_err, 0);
    rxq.delete();

    // nine bytes into an eight-deep FIFO with the consumer stalled
    rx_ready = 1'b0;
    for (int i = 1; i <= 9; i++)
      send_byte(8'(i), 100);
    check("ovr_set", overrun, 1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_head", rx_data, 32'h01);
    rx_ready = 1'b1;
    tick(20);
    check("ovr_count", rxq.size(), 8);
    for (int i = 0; i < 8; i++)
      check("ovr_byte", qat(i), 32'(i + 1));
    check("ovr_drained", rx_valid, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    check("ovr_clr", overrun, 0);
    rxq.delete();

    // bit_div 0 uses DEFAULT_DIV (64 in this bench), bit_div 3 clamps to 8
    bit_div = 20'd0;
    send_byte(8'hC9, 64);
    tick(10);
    check("dflt_count", rxq.size(), 1);
    check("dflt_byte", qat(0), 32'hC9);
    rxq.delete();
    bit_div = 20'd3;
    send_byte(8'h96, 8);
    send_byte(8'h3C, 8);
    tick(10);
    check("clamp_count", rxq.size(), 2);
    check("clamp_byte0", qat(0), 32'h96);
    check("clamp_byte1", qat(1), 32'h3C);
    rxq.delete();

    // reset in the middle of a frame empties the FIFO and drops the partial byte
    bit_div = 20'd100;
    rx_ready = 1'b0;
    send_byte(8'h33, 100);
    check("pre_rst_valid", rx_valid, 1);
    rx_in = 1'b0;
    tick(100);
    for (int i = 0; i < 4; i++) begin
      rx_in = (i == 0) ? 1'b0 : 1'b1;
      tick(100);
    end
    check("mid_busy", busy, 1);
    reset = 1'b1;
    rx_in = 1'b1;
    tick(3);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;
    tick(5);
    rx_ready = 1'b1;
    send_byte(8'h7E, 100);
    tick(10);
    check("post_rst_count", rxq.size(), 1);
    check("post_rst_byte", qat(0), 32'h7E);
    rxq.delete();

`ifdef COCO_RX_PARITY_EN
    // 0x07 has odd weight, so an even-parity bit of 0 is wrong
    send_frame(8'h07, 100, 1'b1, 1'b1);
    tick(110);
    check("par_count", rxq.size(), 1);
    check("par_byte", qat(0), 32'h07);
    check("par_err_set", parity_err, 1);
`else
    check("par_tied_low", parity_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
